div_32bit: RTL

Iterative 32-bit divider executing RV32M DIV, DIVU, REM and REMU in the execute stage of the pipeline. It sits beside the combinational ALU and holds the pipeline through `busy_o` while it runs. It uses radix-2 restoring division: one quotient bit per cycle and a fixed latency for every operand pair, so stall control stays simple. RISC-V special cases (divide by zero, signed overflow) are resolved internally; the block never traps.

---
 rtl/div_32bit.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/div_32bit.sv
// ----------------------------------------------------------------------------
// div_32bit
//
// Iterative radix-2 restoring divider for RV32M DIV / DIVU / REM / REMU.
// It produces one quotient bit per clock. Every operand pair takes the same
// number of cycles, so the pipeline can stall on busy_o without having to
// predict how long an operation will take. Divide-by-zero and signed
// overflow are flagged when the operation starts and substituted at the
// final write, so they also take the normal number of cycles.
//
// Ports
//   clk_i    in   1   clock, rising edge
//   rst_ni   in   1   asynchronous reset, active low
//   start_i  in   1   operation request (taken in IDLE, or on the DONE exit edge)
//   op_i     in   2   funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   rs1_i    in  32   dividend, sampled with start_i
//   rs2_i    in  32   divisor, sampled with start_i
//   flush_i  in   1   abort; returns to IDLE without producing a result
//   busy_o   out  1   high while in CALC or DONE
//   done_o   out  1   single-cycle pulse; rd_o holds the new result
//   rd_o     out 32   last completed result, held until the next completion
//
// State | meaning
// ------+--------------------------------------------------------------------
// IDLE  | waiting for start_i
// CALC  | 32 shift/trial-subtract iterations, one per clock
// DONE  | rd_o just written, done_o high for this one cycle
// ----------------------------------------------------------------------------
module div_32bit (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] rd_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;

    logic [5:0]  cnt_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic [31:0] rs1_q;
    logic        is_rem_q;
    logic        neg_quo_q;
    logic        neg_rem_q;
    logic        div_zero_q;
    logic        ovf_q;

    logic        load;
    logic        iterate;
    logic        write_rd;

    // ------------------------------------------------------------------
    // Operand preparation at start: magnitudes for the signed ops, and
    // the special-case flags that override the arithmetic at the end.
    // ------------------------------------------------------------------
    logic        op_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        start_ok;
    logic        in_div_zero;
    logic        in_ovf;

    always_comb begin
        op_signed   = ~op_i[0];
        a_neg       = op_signed & rs1_i[31];
        b_neg       = op_signed & rs2_i[31];
        a_mag       = a_neg ? (32'd0 - rs1_i) : rs1_i;
        b_mag       = b_neg ? (32'd0 - rs2_i) : rs2_i;
        start_ok    = start_i & ~flush_i;
        in_div_zero = (rs2_i == 32'd0);
        in_ovf      = op_signed & (rs1_i == 32'h8000_0000) & (rs2_i == 32'hFFFF_FFFF);
    end

    // ------------------------------------------------------------------
    // One restoring step. The partial remainder is always below the
    // divisor, so after the shift it fits in 33 bits; the compare is done
    // at that width and the subtraction only needs the low 32 bits
    // because a successful result is again below the divisor.
    // ------------------------------------------------------------------
    logic [32:0] rem_sh;
    logic [31:0] quo_sh;
    logic        trial_ok;
    logic [31:0] rem_nx;
    logic [31:0] quo_nx;

    always_comb begin
        rem_sh   = {rem_q, quo_q[31]};
        quo_sh   = {quo_q[30:0], 1'b0};
        trial_ok = (rem_sh >= {1'b0, dvs_q});
        rem_nx   = trial_ok ? (rem_sh[31:0] - dvs_q) : rem_sh[31:0];
        quo_nx   = {quo_sh[31:1], trial_ok};
    end

    // Result selection for the final iteration: sign fix, then overrides.
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] result;

    always_comb begin
        quo_fix = neg_quo_q ? (32'd0 - quo_nx) : quo_nx;
        rem_fix = neg_rem_q ? (32'd0 - rem_nx) : rem_nx;
        if (div_zero_q) begin
            quo_fix = 32'hFFFF_FFFF;
            rem_fix = rs1_q;
        end else if (ovf_q) begin
            quo_fix = 32'h8000_0000;
            rem_fix = 32'd0;
        end
        result = is_rem_q ? rem_fix : quo_fix;
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        iterate  = 1'b0;
        write_rd = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    load    = 1'b1;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    iterate = 1'b1;
                    if (cnt_q == 6'd31) begin
                        write_rd = 1'b1;
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // The DONE exit edge doubles as the first IDLE sampling edge,
                // which keeps back-to-back operations at one per 33 cycles.
                if (start_ok) begin
                    load    = 1'b1;
                    state_d = S_CALC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= 6'd0;
            rem_q      <= 32'd0;
            quo_q      <= 32'd0;
            dvs_q      <= 32'd0;
            rs1_q      <= 32'd0;
            is_rem_q   <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (load) begin
            cnt_q      <= 6'd0;
            rem_q      <= 32'd0;
            quo_q      <= a_mag;
            dvs_q      <= b_mag;
            rs1_q      <= rs1_i;
            is_rem_q   <= op_i[1];
            neg_quo_q  <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            div_zero_q <= in_div_zero;
            ovf_q      <= in_ovf;
        end else if (iterate) begin
            cnt_q <= cnt_q + 6'd1;
            rem_q <= rem_nx;
            quo_q <= quo_nx;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_o <= 32'd0;
        end else if (write_rd) begin
            rd_o <= result;
        end
    end

    // Both flags decode the state register only, so neither output has a
    // combinational path from the inputs.
    assign busy_o = (state_q != S_IDLE);
    assign done_o = (state_q == S_DONE);

endmodule
